// File: rtl/c0_pkg.sv
// C0 sequencer shared types: FSM states, instruction
// classes, bank source-select encodings.
package c0_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_FETCH2 = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] CL_MOV = 2'b00;
  localparam logic [1:0] CL_ALU = 2'b01;
  localparam logic [1:0] CL_LDI = 2'b10;
  localparam logic [1:0] CL_CTL = 2'b11;

  localparam logic [1:0] MS_ALU = 2'b00;
  localparam logic [1:0] MS_REG = 2'b01;
  localparam logic [1:0] MS_IMM = 2'b10;

  typedef struct packed {
    logic [1:0] cls;
    logic [2:0] a;
    logic [2:0] b;
  } insn_t;

  function automatic logic is_halt(insn_t i);
    return (i.cls == CL_CTL) && i.a[2];
  endfunction

  // LDI and JMP both carry a second byte
  function automatic logic is_two(insn_t i);
    return (i.cls == CL_LDI) ||
           ((i.cls == CL_CTL) && !i.a[2]);
  endfunction

endpackage

// File: rtl/c0_pc.sv
// C0 program counter: 8-bit, wraps silently,
// load wins over increment.
module c0_pc (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_inc,
  input  logic       i_ld,
  input  logic [7:0] i_d,
  output logic [7:0] o_pc
);

  logic [7:0] r_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_pc <= 8'h00;
    else if (i_ld)
      r_pc <= i_d;
    else if (i_inc)
      r_pc <= r_pc + 8'd1;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/c0_sequencer.sv
// C0 fetch/decode/execute sequencer driving the
// register bank write controls.
module c0_sequencer
  import c0_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  output logic [7:0] MEM_ADDR,
  output logic       MEM_REQ,
  input  logic [7:0] MEM_DATA,
  input  logic       MEM_RDY,
  output logic [1:0] MS,
  output logic [2:0] RS,
  output logic       E,
  output logic [7:0] IMM,
  output logic [2:0] SRC,
  output logic [2:0] ALUOP,
  output logic       HALTED
);

  state_t     r_state;
  state_t     w_next;
  insn_t      r_ir;
  logic [1:0] r_ms;
  logic [2:0] r_rs;
  logic [2:0] r_src;
  logic [2:0] r_aluop;
  logic [7:0] r_imm;

  logic       w_ld_ir;
  logic       w_op;
  logic       w_jmp;
  logic       w_pc_inc;
  logic       w_pc_ld;
  logic       w_dec_halt;
  logic       w_dec_two;
  logic       w_dec_one;
  logic [7:0] w_pc;

  assign w_ld_ir  = (r_state == ST_FETCH) && MEM_RDY;
  assign w_op     = (r_state == ST_FETCH2) && MEM_RDY;
  assign w_jmp    = (r_ir.cls == CL_CTL);
  assign w_pc_inc = w_ld_ir || (w_op && !w_jmp);
  assign w_pc_ld  = w_op && w_jmp;

  assign w_dec_halt = is_halt(r_ir);
  assign w_dec_two  = is_two(r_ir);
  assign w_dec_one  = !r_ir.cls[1];

  c0_pc u_pc (
    .i_clk (CLK),
    .i_rst (RST),
    .i_inc (w_pc_inc),
    .i_ld  (w_pc_ld),
    .i_d   (MEM_DATA),
    .o_pc  (w_pc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        w_next = ST_FETCH;
      ST_FETCH:
        if (MEM_RDY)
          w_next = ST_DECODE;
      ST_DECODE:
        unique case (1'b1)
          w_dec_halt: w_next = ST_HALT;
          w_dec_two:  w_next = ST_FETCH2;
          w_dec_one:  w_next = ST_EXEC;
          default:    w_next = ST_EXEC;
        endcase
      ST_FETCH2:
        if (MEM_RDY)
          w_next = w_jmp ? ST_FETCH : ST_EXEC;
      ST_EXEC:
        w_next = ST_FETCH;
      ST_HALT:
        w_next = ST_HALT;
      default:
        w_next = ST_IDLE;
    endcase
  end

  // state-decoded strobes drop with the async reset
  always_comb begin
    MEM_REQ = 1'b0;
    E       = 1'b0;
    HALTED  = 1'b0;
    unique case (r_state)
      ST_FETCH:  MEM_REQ = 1'b1;
      ST_FETCH2: MEM_REQ = 1'b1;
      ST_EXEC:   E       = 1'b1;
      ST_HALT:   HALTED  = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_ir <= '0;
    else if (w_ld_ir)
      r_ir <= insn_t'(MEM_DATA);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ms    <= MS_ALU;
      r_rs    <= 3'd0;
      r_src   <= 3'd0;
      r_aluop <= 3'd0;
    end else if (r_state == ST_DECODE) begin
      unique case (1'b1)
        r_ir.cls == CL_MOV: begin
          r_ms  <= MS_REG;
          r_rs  <= r_ir.a;
          r_src <= r_ir.b;
        end
        r_ir.cls == CL_ALU: begin
          r_ms    <= MS_ALU;
          r_aluop <= r_ir.a;
          r_rs    <= r_ir.b;
          r_src   <= 3'd0;
        end
        r_ir.cls == CL_LDI: begin
          r_ms <= MS_IMM;
          r_rs <= r_ir.a;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_imm <= 8'h00;
    else if (w_op && !w_jmp)
      r_imm <= MEM_DATA;
  end

  assign MEM_ADDR = w_pc;
  assign MS       = r_ms;
  assign RS       = r_rs;
  assign SRC      = r_src;
  assign ALUOP    = r_aluop;
  assign IMM      = r_imm;

endmodule

// File: tb/tb_c0_sequencer.sv
// Self-checking bench for c0_sequencer: vector table
// plus hand sequences, write-backs via scoreboard.
module tb_c0_sequencer;

  logic       CLK;
  logic       RST;
  logic [7:0] MEM_ADDR;
  logic       MEM_REQ;
  logic [7:0] MEM_DATA;
  logic       MEM_RDY;
  logic [1:0] MS;
  logic [2:0] RS;
  logic       E;
  logic [7:0] IMM;
  logic [2:0] SRC;
  logic [2:0] ALUOP;
  logic       HALTED;

  logic [7:0] rom [256];

  assign MEM_DATA = rom[MEM_ADDR];

  c0_sequencer dut (
    .CLK      (CLK),
    .RST      (RST),
    .MEM_ADDR (MEM_ADDR),
    .MEM_REQ  (MEM_REQ),
    .MEM_DATA (MEM_DATA),
    .MEM_RDY  (MEM_RDY),
    .MS       (MS),
    .RS       (RS),
    .E        (E),
    .IMM      (IMM),
    .SRC      (SRC),
    .ALUOP    (ALUOP),
    .HALTED   (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] ms;
    logic [2:0] rs;
    logic [2:0] src;
    logic [2:0] aluop;
    logic [7:0] imm;
    int         cyc;
  } wr_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         e_cyc;
    logic [1:0] ms;
    logic [2:0] rs;
    logic [2:0] src;
    logic [2:0] aluop;
    logic [7:0] imm;
    int         pr_cyc;
    logic [7:0] pr_addr;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[9];
  int   n_cmp;
  int   n_err;
  int   cyc;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    wr_t w;
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    if (E) begin
      if (exp_q.size() == 0) begin
        chk("spurious_E", 32'(E), 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("E_cycle", cyc, w.cyc);
        chk("MS", 32'(MS), 32'(w.ms));
        chk("RS", 32'(RS), 32'(w.rs));
        chk("SRC", 32'(SRC), 32'(w.src));
        chk("ALUOP", 32'(ALUOP), 32'(w.aluop));
        chk("IMM", 32'(IMM), 32'(w.imm));
      end
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++)
      rom[i] = 8'hE0;
  endtask

  task automatic do_reset();
    RST     = 1'b1;
    MEM_RDY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    cyc = 0;
    exp_q.delete();
  endtask

  task automatic push(input logic [1:0] ms,
                      input logic [2:0] rs,
                      input logic [2:0] src,
                      input logic [2:0] aluop,
                      input logic [7:0] imm,
                      input int c);
    wr_t w;
    w.ms    = ms;
    w.rs    = rs;
    w.src   = src;
    w.aluop = aluop;
    w.imm   = imm;
    w.cyc   = c;
    exp_q.push_back(w);
  endtask

  int nreq;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    cyc     = 0;
    RST     = 1'b1;
    MEM_RDY = 1'b1;
    rom_clear();

    vecs[0] = '{8'h0B, 8'hE0, 3, 2'b01, 3'd1,
                3'd3, 3'd0, 8'h00, 3, 8'h01};
    vecs[1] = '{8'h6D, 8'hE0, 3, 2'b00, 3'd5,
                3'd0, 3'd5, 8'h00, 3, 8'h01};
    vecs[2] = '{8'h90, 8'h5A, 4, 2'b10, 3'd2,
                3'd0, 3'd0, 8'h5A, 4, 8'h02};
    vecs[3] = '{8'hC0, 8'h10, 0, 2'b00, 3'd0,
                3'd0, 3'd0, 8'h00, 4, 8'h10};
    vecs[4] = '{8'h38, 8'hE0, 3, 2'b01, 3'd7,
                3'd0, 3'd0, 8'h00, 3, 8'h01};
    vecs[5] = '{8'h47, 8'hE0, 3, 2'b00, 3'd7,
                3'd0, 3'd0, 8'h00, 3, 8'h01};
    vecs[6] = '{8'hD8, 8'h20, 0, 2'b00, 3'd0,
                3'd0, 3'd0, 8'h00, 4, 8'h20};
    vecs[7] = '{8'hF8, 8'hE0, 0, 2'b00, 3'd0,
                3'd0, 3'd0, 8'h00, 3, 8'h01};
    vecs[8] = '{8'h97, 8'hFF, 4, 2'b10, 3'd2,
                3'd0, 3'd0, 8'hFF, 4, 8'h02};

    // reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_addr", 32'(MEM_ADDR), 32'h00);
    chk("rst_req", 32'(MEM_REQ), 32'd0);
    chk("rst_E", 32'(E), 32'd0);
    chk("rst_MS", 32'(MS), 32'd0);
    chk("rst_RS", 32'(RS), 32'd0);
    chk("rst_SRC", 32'(SRC), 32'd0);
    chk("rst_ALUOP", 32'(ALUOP), 32'd0);
    chk("rst_IMM", 32'(IMM), 32'd0);
    chk("rst_halted", 32'(HALTED), 32'd0);

    // first request one cycle after leaving IDLE
    rom_clear();
    rom[0] = 8'h0B;
    do_reset();
    chk("idle_noreq", 32'(MEM_REQ), 32'd0);
    push(2'b01, 3'd1, 3'd3, 3'd0, 8'h00, 3);
    step();
    chk("first_req", 32'(MEM_REQ), 32'd1);
    step();
    chk("decode_noreq", 32'(MEM_REQ), 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("first_sb_empty", exp_q.size(), 0);

    for (int v = 0; v < 9; v++) begin
      rom_clear();
      rom[0] = vecs[v].b0;
      rom[1] = vecs[v].b1;
      do_reset();
      if (vecs[v].e_cyc != 0)
        push(vecs[v].ms, vecs[v].rs, vecs[v].src,
             vecs[v].aluop, vecs[v].imm,
             vecs[v].e_cyc);
      for (int k = 0; k < 12; k++) begin
        step();
        if (cyc == vecs[v].pr_cyc)
          chk($sformatf("v%0d_addr", v),
              32'(MEM_ADDR), 32'(vecs[v].pr_addr));
      end
      chk($sformatf("v%0d_halted", v),
          32'(HALTED), 32'd1);
      chk($sformatf("v%0d_sb_empty", v),
          exp_q.size(), 0);
    end

    // three wait cycles during FETCH
    rom_clear();
    rom[0] = 8'h0B;
    do_reset();
    MEM_RDY = 1'b0;
    push(2'b01, 3'd1, 3'd3, 3'd0, 8'h00, 6);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("wait_req", 32'(MEM_REQ), 32'd1);
      chk("wait_addr", 32'(MEM_ADDR), 32'h00);
      if (cyc == 4) MEM_RDY = 1'b1;
    end
    for (int k = 0; k < 6; k++) step();
    chk("wait_sb_empty", exp_q.size(), 0);

    // LDI at FF: operand from 00, then HALT at 01
    rom_clear();
    rom[8'h00] = 8'hC0;
    rom[8'h01] = 8'hFF;
    rom[8'hFF] = 8'h90;
    do_reset();
    push(2'b10, 3'd2, 3'd0, 3'd0, 8'hC0, 7);
    for (int k = 0; k < 10; k++) begin
      step();
      if (cyc == 4)
        chk("wrap_ff", 32'(MEM_ADDR), 32'hFF);
      if (cyc == 6) begin
        chk("wrap_opaddr", 32'(MEM_ADDR), 32'h00);
        chk("wrap_opreq", 32'(MEM_REQ), 32'd1);
      end
      if (cyc == 7)
        chk("wrap_pc01", 32'(MEM_ADDR), 32'h01);
    end
    chk("halt_flag", 32'(HALTED), 32'd1);
    chk("halt_pc", 32'(MEM_ADDR), 32'h02);
    nreq = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (MEM_REQ) nreq++;
    end
    chk("halt_noreq", nreq, 0);
    chk("halt_pc_frozen", 32'(MEM_ADDR), 32'h02);
    chk("halt_sb_empty", exp_q.size(), 0);

    // async reset in the middle of EXEC
    rom_clear();
    rom[0] = 8'h0B;
    do_reset();
    push(2'b01, 3'd1, 3'd3, 3'd0, 8'h00, 3);
    for (int k = 0; k < 3; k++) step();
    chk("pre_rst_E", 32'(E), 32'd1);
    #1 RST = 1'b1;
    #1;
    chk("async_E", 32'(E), 32'd0);
    chk("async_req", 32'(MEM_REQ), 32'd0);
    chk("async_addr", 32'(MEM_ADDR), 32'h00);
    @(negedge CLK);
    RST = 1'b0;
    cyc = 0;
    push(2'b01, 3'd1, 3'd3, 3'd0, 8'h00, 3);
    for (int k = 0; k < 8; k++) begin
      step();
      if (cyc == 1) begin
        chk("restart_addr", 32'(MEM_ADDR), 32'h00);
        chk("restart_req", 32'(MEM_REQ), 32'd1);
      end
    end
    chk("restart_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
